obc_bitplane_feeder: RTL and testbench

Bit-plane serializer that drives the 16-bit slice inputs and sign flag `m` of the OBC 16-point DFT ROM/combiner stage. It accepts 16 two's-complement samples one per cycle over a valid/ready stream into a ping-pong register buffer. It then emits the frame one bit-plane per cycle, LSB first, to the downstream ROM + shift-accumulator path. It is the producing end of the slice interface that the ROM combiner consumes.

---
 rtl/obc_dft_pkg.sv | 25 ++
 rtl/obc_sample_bank.sv | 60 ++++++
 rtl/obc_bitplane_feeder.sv | 108 ++++++++++
 tb/tb_obc_bitplane_feeder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/obc_dft_pkg.sv
// Shared types and constants for the OBC 16-point DFT slice path
// (bit-plane feeder, ROM combiner, shift-accumulator wrappers).
package obc_dft_pkg;

  localparam int N_PTS     = 16;
  localparam int DEFAULT_W = 16;

  typedef logic [3:0] pt_idx_t;

  typedef enum logic {
    BANK_A = 1'b0,
    BANK_B = 1'b1
  } bank_sel_t;

  typedef enum logic [1:0] {
    BS_EMPTY   = 2'd0,
    BS_FILLING = 2'd1,
    BS_FULL    = 2'd2
  } bank_state_t;

  function automatic bank_sel_t other_bank(input bank_sel_t b);
    return (b == BANK_A) ? BANK_B : BANK_A;
  endfunction

endpackage

// File: rtl/obc_sample_bank.sv
// One ping-pong bank: 16 x W sample registers plus its EMPTY/FILLING/FULL
// lifecycle. Contents are frozen while FULL; reads return one bit-plane.
module obc_sample_bank
  import obc_dft_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we_i,
  input  pt_idx_t                widx_i,
  input  logic [W-1:0]           wdata_i,
  input  logic                   set_full_i,
  input  logic                   clr_full_i,
  input  logic [$clog2(W)-1:0]   plane_i,
  output logic [N_PTS-1:0]       plane_o,
  output logic                   full_o
);

  bank_state_t state_q, state_d;
  logic [W-1:0] mem_q [N_PTS];
  logic         wr_ok;

  assign wr_ok  = we_i && (state_q != BS_FULL);
  assign full_o = (state_q == BS_FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= BS_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BS_EMPTY: begin
        if (wr_ok && set_full_i) state_d = BS_FULL;
        else if (wr_ok)          state_d = BS_FILLING;
      end
      BS_FILLING: begin
        if (wr_ok && set_full_i) state_d = BS_FULL;
      end
      BS_FULL: begin
        if (clr_full_i) state_d = BS_EMPTY;
      end
      default: state_d = BS_EMPTY;
    endcase
  end

  // Sample storage carries no reset; stale data is never visible because
  // the bank only reads out once all 16 entries have been rewritten.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[widx_i] <= wdata_i;
  end

  always_comb begin
    plane_o = '0;
    for (int i = 0; i < N_PTS; i++) plane_o[i] = mem_q[i][plane_i];
  end

endmodule

// File: rtl/obc_bitplane_feeder.sv
// Ping-pong bit-plane serializer: loads 16 signed samples, then emits the
// frame LSB-plane first with m/p_last on the sign plane.
module obc_bitplane_feeder
  import obc_dft_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [W-1:0]     s_data,
  output logic [N_PTS-1:0] x,
  output logic             m,
  output logic             p_valid,
  input  logic             p_ready,
  output logic             p_first,
  output logic             p_last
);

  localparam int PW = $clog2(W);

  bank_sel_t       wr_bank_q, wr_bank_d;
  bank_sel_t       rd_bank_q, rd_bank_d;
  pt_idx_t         wr_idx_q, wr_idx_d;
  logic [PW-1:0]   plane_q, plane_d;

  logic            full_a, full_b;
  logic [N_PTS-1:0] plane_a, plane_b;
  logic            s_fire, p_fire, plane_last, wr_last;

  // s_ready only ever sees registered full flags, never p_ready.
  assign s_ready    = (wr_bank_q == BANK_B) ? !full_b : !full_a;
  assign p_valid    = (rd_bank_q == BANK_B) ?  full_b :  full_a;
  assign s_fire     = s_valid && s_ready;
  assign p_fire     = p_valid && p_ready;
  assign plane_last = (plane_q == PW'(W-1));
  assign wr_last    = (wr_idx_q == pt_idx_t'(N_PTS-1));

  assign x       = (rd_bank_q == BANK_B) ? plane_b : plane_a;
  assign m       = plane_last;
  assign p_last  = plane_last;
  assign p_first = (plane_q == '0);

  obc_sample_bank #(.W(W)) u_bank_a (
    .clk        (clk),
    .rst        (rst),
    .we_i       (s_fire && (wr_bank_q == BANK_A)),
    .widx_i     (wr_idx_q),
    .wdata_i    (s_data),
    .set_full_i (s_fire && wr_last && (wr_bank_q == BANK_A)),
    .clr_full_i (p_fire && plane_last && (rd_bank_q == BANK_A)),
    .plane_i    (plane_q),
    .plane_o    (plane_a),
    .full_o     (full_a)
  );

  obc_sample_bank #(.W(W)) u_bank_b (
    .clk        (clk),
    .rst        (rst),
    .we_i       (s_fire && (wr_bank_q == BANK_B)),
    .widx_i     (wr_idx_q),
    .wdata_i    (s_data),
    .set_full_i (s_fire && wr_last && (wr_bank_q == BANK_B)),
    .clr_full_i (p_fire && plane_last && (rd_bank_q == BANK_B)),
    .plane_i    (plane_q),
    .plane_o    (plane_b),
    .full_o     (full_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_q <= BANK_A;
      rd_bank_q <= BANK_A;
      wr_idx_q  <= '0;
      plane_q   <= '0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q  <= wr_idx_d;
      plane_q   <= plane_d;
    end
  end

  always_comb begin
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_idx_d  = wr_idx_q;
    plane_d   = plane_q;
    if (s_fire) begin
      if (wr_last) begin
        wr_idx_d  = '0;
        wr_bank_d = other_bank(wr_bank_q);
      end else begin
        wr_idx_d  = wr_idx_q + pt_idx_t'(1);
      end
    end
    if (p_fire) begin
      if (plane_last) begin
        plane_d   = '0;
        rd_bank_d = other_bank(rd_bank_q);
      end else begin
        plane_d   = plane_q + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_obc_bitplane_feeder.sv
// Bench for obc_bitplane_feeder: random and directed frames checked against
// a frame-queue reference model; a second W=8 instance covers sign planes.
module tb_obc_bitplane_feeder;

  localparam int WA = 16;
  localparam int WB = 8;

  typedef logic [15:0][WA-1:0] frame_t;

  logic clk = 1'b0;
  logic rst;

  logic          s_valid, s_ready, m, p_valid, p_ready, p_first, p_last;
  logic [WA-1:0] s_data;
  logic [15:0]   x;

  logic          s_valid8, s_ready8, m8, p_valid8, p_ready8, p_first8, p_last8;
  logic [WB-1:0] s_data8;
  logic [15:0]   x8;

  always #5 clk = ~clk;

  obc_bitplane_feeder #(.W(WA)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .x(x), .m(m), .p_valid(p_valid), .p_ready(p_ready), .p_first(p_first), .p_last(p_last)
  );

  obc_bitplane_feeder #(.W(WB)) dut8 (
    .clk(clk), .rst(rst), .s_valid(s_valid8), .s_ready(s_ready8), .s_data(s_data8),
    .x(x8), .m(m8), .p_valid(p_valid8), .p_ready(p_ready8), .p_first(p_first8), .p_last(p_last8)
  );

  int n_total = 0;
  int n_fail  = 0;

  frame_t        frames[$];
  logic [WA-1:0] partial[$];
  int            mb = 0;
  logic [15:0]   last_x;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    frames.delete();
    partial.delete();
    mb = 0;
  endtask

  // One clock: drive at negedge, compare outputs to the model, then advance
  // the model by whatever handshakes the model says happen at the posedge.
  task automatic cycle(input logic sv, input logic [WA-1:0] sd, input logic pr);
    logic        exp_sr, exp_pv, sfire, pfire;
    logic [15:0] ex;
    frame_t      f;
    @(negedge clk);
    s_valid = sv; s_data = sd; p_ready = pr;
    #1;
    exp_sr = (frames.size() < 2);
    exp_pv = (frames.size() != 0);
    chk("s_ready", {31'd0, s_ready}, {31'd0, exp_sr});
    chk("p_valid", {31'd0, p_valid}, {31'd0, exp_pv});
    chk("p_first", {31'd0, p_first}, {31'd0, mb == 0});
    chk("p_last",  {31'd0, p_last},  {31'd0, mb == WA-1});
    chk("m",       {31'd0, m},       {31'd0, mb == WA-1});
    last_x = x;
    if (exp_pv) begin
      f = frames[0];
      for (int i = 0; i < 16; i++) ex[i] = f[i][mb];
      chk("x_plane", {16'd0, x}, {16'd0, ex});
    end
    sfire = sv && exp_sr;
    pfire = pr && exp_pv;
    @(posedge clk);
    if (pfire) begin
      mb++;
      if (mb == WA) begin
        void'(frames.pop_front());
        mb = 0;
      end
    end
    if (sfire) begin
      partial.push_back(sd);
      if (partial.size() == 16) begin
        for (int i = 0; i < 16; i++) f[i] = partial[i];
        frames.push_back(f);
        partial.delete();
      end
    end
  endtask

  task automatic drain();
    int guard = 0;
    while ((frames.size() != 0 || mb != 0) && guard < 200) begin
      cycle(1'b0, '0, 1'b1);
      guard++;
    end
    chk("drain_done", frames.size(), 0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    s_valid = 1'b0; p_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_p_valid", {31'd0, p_valid}, 32'd0);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
    chk("rst_p_first", {31'd0, p_first}, 32'd1);
    chk("rst_p_last",  {31'd0, p_last},  32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [15:0] ramp_plane(input int b);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[i] = (i >> b) & 1;
    return r;
  endfunction

  initial begin
    logic [15:0] tbl [4];
    tbl[0] = 16'hAAAA; tbl[1] = 16'hCCCC; tbl[2] = 16'hF0F0; tbl[3] = 16'hFF00;
    rst = 1'b1;
    s_valid = 1'b0; s_data = '0; p_ready = 1'b0;
    s_valid8 = 1'b0; s_data8 = '0; p_ready8 = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_s_ready", {31'd0, s_ready}, 32'd1);
    chk("reset_p_valid", {31'd0, p_valid}, 32'd0);
    chk("reset_p_first", {31'd0, p_first}, 32'd1);
    chk("reset_p_last",  {31'd0, p_last},  32'd0);
    chk("reset_m",       {31'd0, m},       32'd0);
    rst = 1'b0;

    // Ramp frame: sample i = i.
    for (int i = 0; i < 16; i++) cycle(1'b1, WA'(i), 1'b1);
    for (int b = 0; b < WA; b++) begin
      cycle(1'b0, '0, 1'b1);
      chk("ramp_const", {16'd0, last_x}, {16'd0, (b < 4) ? tbl[b] : 16'h0000});
      chk("ramp_arith", {16'd0, last_x}, {16'd0, ramp_plane(b)});
    end
    drain();

    // All -1 frame.
    for (int i = 0; i < 16; i++) cycle(1'b1, '1, 1'b0);
    for (int b = 0; b < WA; b++) begin
      cycle(1'b0, '0, 1'b1);
      chk("neg1_plane", {16'd0, last_x}, 32'h0000FFFF);
    end
    drain();

    // Continuous streaming: s_ready must never drop.
    for (int c = 0; c < 64; c++) begin
      cycle(1'b1, WA'($urandom), 1'b1);
      chk("stream_s_ready", {31'd0, s_ready}, 32'd1);
    end
    for (int c = 0; c < 16; c++) cycle(1'b0, '0, 1'b1);
    drain();

    // Random backpressure with a saturating writer (forces third-frame stalls).
    for (int c = 0; c < 300; c++) cycle(1'b1, WA'($urandom), 1'($urandom_range(0, 1)));
    for (int c = 0; c < 200; c++) cycle(1'($urandom_range(0, 1)), WA'($urandom), 1'($urandom_range(0, 1)));
    for (int c = 0; c < 16; c++) cycle(1'b0, '0, 1'b1);
    drain();

    // Reset after 9 samples, then a clean frame.
    for (int i = 0; i < 9; i++) cycle(1'b1, WA'($urandom), 1'b1);
    async_reset();
    for (int i = 0; i < 16; i++) cycle(1'b1, WA'($urandom), 1'b0);
    drain();

    // Reset mid-emission at plane 7, then a clean frame.
    for (int i = 0; i < 16; i++) cycle(1'b1, WA'($urandom), 1'b0);
    for (int b = 0; b < 7; b++) cycle(1'b0, '0, 1'b1);
    chk("pre_rst_p_valid", {31'd0, p_valid}, 32'd1);
    async_reset();
    for (int i = 0; i < 16; i++) cycle(1'b1, WA'(i * 4099 + 7), 1'b0);
    drain();

    // W=8 sign plane: samples {-128, 127, 0, ...}.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      s_valid8 = 1'b1;
      s_data8  = (i == 0) ? 8'h80 : (i == 1) ? 8'h7F : 8'h00;
      #1;
      chk("w8_s_ready", {31'd0, s_ready8}, 32'd1);
    end
    @(negedge clk);
    s_valid8 = 1'b0;
    p_ready8 = 1'b1;
    for (int b = 0; b < WB; b++) begin
      #1;
      chk("w8_p_valid", {31'd0, p_valid8}, 32'd1);
      chk("w8_x0",      {31'd0, x8[0]},    {31'd0, b == WB-1});
      chk("w8_x1",      {31'd0, x8[1]},    {31'd0, b != WB-1});
      chk("w8_rest",    {16'd0, x8 & 16'hFFFC}, 32'd0);
      chk("w8_m",       {31'd0, m8},       {31'd0, b == WB-1});
      chk("w8_p_first", {31'd0, p_first8}, {31'd0, b == 0});
      @(negedge clk);
    end
    #1;
    chk("w8_empty", {31'd0, p_valid8}, 32'd0);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
